ray_scan_host: RTL and testbench
================================

RAY_SCAN_HOST -- requirements
Module: ray_scan_host

Interface
REQ-001 Parameter COLS, default 128, number of pixel columns per frame (2..2^COL_W).
REQ-002 Parameter ROWS, default 64, number of pixel rows per frame (2..2^ROW_W).
REQ-003 Parameter COL_W, default 7, column address width.
REQ-004 Parameter ROW_W, default 6, row address width.
REQ-005 Parameter PIX_W, default 12, pixel colour width.
REQ-006 tracer_clk  in  1  sole clock; every register updates on its rising edge.
REQ-007 rst  in  1  synchronous, active-low reset.
REQ-008 start  in  1  single-cycle frame start request; ignored unless IDLE.
REQ-009 continuous  in  1  1 = restart a new frame automatically after frame_done.
REQ-010 ray_req  out  1  ray request valid to tracer.
REQ-011 ray_col / ray_row  out  COL_W / ROW_W  pixel coordinate of the current request.
REQ-012 ray_ack  in  1  tracer result valid; completes transaction when ray_req=1.
REQ-013 ray_color  in  PIX_W  traced colour, sampled on ray_req&ray_ack.
REQ-014 ray_hit  in  1  pixel collision flag, sampled on ray_req&ray_ack.
REQ-015 fb_we  out  1  framebuffer write strobe.
REQ-016 col_addr / row_addr / dout  out  COL_W / ROW_W / PIX_W  framebuffer write address and data.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 frame_done  out  1  one-cycle pulse on the last pixel write of a frame.
REQ-019 collision_sig  out  4  {left,right,front,back} flags of the last completed frame.

Function
REQ-020 FSM states IDLE, REQ, WRITE; IDLE->REQ on start, or on frame_done when continuous=1.
REQ-021 REQ drives ray_req=1 with ray_col/ray_row held stable until ray_req&ray_ack; next state WRITE.
REQ-022 WRITE drives fb_we=1 for exactly one cycle with col_addr/row_addr = captured coordinate and dout = captured colour.
REQ-023 Peak throughput is one pixel per 2 cycles; ray_ack arriving in the first REQ cycle adds no stall.
REQ-024 Scan order: column increments per pixel; at COLS-1 column wraps to 0 and row increments; at ROWS-1 row wraps to 0.
REQ-025 The write of pixel (COLS-1, ROWS-1) asserts frame_done in the same cycle as fb_we; next state is REQ if continuous=1, else IDLE.
REQ-026 Counters reset to (0,0) at every frame start; ray_ack outside REQ is ignored.
REQ-027 start asserted while busy=1 has no effect; continuous deasserting mid-frame ends the scan after the current frame.
REQ-028 fb_we, ray_req, and frame_done are 0 in IDLE; col_addr/row_addr/dout hold their last written values.

Reset
REQ-029 rst=0 at any tracer_clk edge forces IDLE, counters to 0, and all outputs (including collision_sig and dout) to 0, aborting any frame in progress without a write.

Configuration
REQ-030 Macro RAY_SCAN_COLLISION_EN defined: per-frame working flags are cleared at frame start; they set left on a hit at col 0, right on a hit at col COLS-1, front on any hit, and back on a hit at row ROWS-1.
REQ-031 With RAY_SCAN_COLLISION_EN defined, the working flags are copied to collision_sig in the frame_done cycle, with the final pixel's hit included.
REQ-032 Macro RAY_SCAN_COLLISION_EN undefined: no collision logic exists, ray_hit is unused, and collision_sig is tied to 4'b0000.

Verification
REQ-033 COLS=4, ROWS=2, ray_ack tied 1, one start pulse -> 8 fb_we pulses 2 cycles apart in order (0,0),(1,0)..(3,1), one frame_done with the 8th write, then IDLE.
REQ-034 ray_ack delayed 5 cycles on pixel (2,0) -> ray_req held 5 cycles, ray_col=2 stable throughout, exactly one write of the colour sampled at ack.
REQ-035 continuous=1 for two frames -> second frame begins REQ (0,0) the cycle after frame_done; start pulses mid-frame produce no extra writes.
REQ-036 With RAY_SCAN_COLLISION_EN, ray_hit=1 only at (0,1) and (3,1), ROWS=2 -> collision_sig=4'b1111 after frame_done; the next frame with no hits -> 4'b0000.
REQ-037 rst=0 held one cycle during REQ at pixel (3,0) -> next cycle busy=0, ray_req=0, fb_we=0, collision_sig=0; a subsequent start begins at (0,0).

Source files
------------

// File: rtl/ray_scan_host_if.sv
// Tracer request/response and framebuffer write bus for ray_scan_host.
// master = scan host side, slave = tracer/framebuffer side.
interface ray_scan_host_if #(
    parameter int unsigned COL_W = 7,
    parameter int unsigned ROW_W = 6,
    parameter int unsigned PIX_W = 12
);
    logic             ray_req;
    logic [COL_W-1:0] ray_col;
    logic [ROW_W-1:0] ray_row;
    logic             ray_ack;
    logic [PIX_W-1:0] ray_color;
    logic             ray_hit;

    logic             fb_we;
    logic [COL_W-1:0] col_addr;
    logic [ROW_W-1:0] row_addr;
    logic [PIX_W-1:0] dout;

    modport master (
        output ray_req, ray_col, ray_row, fb_we, col_addr, row_addr, dout,
        input  ray_ack, ray_color, ray_hit
    );

    modport slave (
        input  ray_req, ray_col, ray_row, fb_we, col_addr, row_addr, dout,
        output ray_ack, ray_color, ray_hit
    );
endinterface

// File: rtl/ray_scan_host.sv
// Raster scan host: requests one ray per pixel and writes each result to the framebuffer.
// Optional per-frame collision flags are compiled in with `define RAY_SCAN_COLLISION_EN.
module ray_scan_host #(
    parameter int unsigned COLS  = 128,
    parameter int unsigned ROWS  = 64,
    parameter int unsigned COL_W = 7,
    parameter int unsigned ROW_W = 6,
    parameter int unsigned PIX_W = 12
) (
    input  logic                  tracer_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  continuous,
    output logic                  busy,
    output logic                  frame_done,
    output logic [3:0]            collision_sig,
    ray_scan_host_if.master       bus
);

    typedef enum logic [1:0] {StIdle, StReq, StWrite} state_e;

    localparam logic [COL_W-1:0] ColLast = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] RowLast = ROW_W'(ROWS - 1);

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_addr_q, col_addr_d;
    logic [ROW_W-1:0] row_addr_q, row_addr_d;
    logic [PIX_W-1:0] dout_q, dout_d;
    logic             ray_req, fb_we, frame_start, last_pix;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        col_addr_d  = col_addr_q;
        row_addr_d  = row_addr_q;
        dout_d      = dout_q;
        ray_req     = 1'b0;
        fb_we       = 1'b0;
        frame_done  = 1'b0;
        frame_start = 1'b0;
        last_pix    = (col_q == ColLast) && (row_q == RowLast);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StReq;
                    frame_start = 1'b1;
                end
            end
            StReq: begin
                ray_req = 1'b1;
                if (bus.ray_ack) begin
                    state_d    = StWrite;
                    col_addr_d = col_q;
                    row_addr_d = row_q;
                    dout_d     = bus.ray_color;
                end
            end
            StWrite: begin
                fb_we = 1'b1;
                if (last_pix) begin
                    frame_done  = 1'b1;
                    frame_start = continuous;
                    state_d     = continuous ? StReq : StIdle;
                end else begin
                    state_d = StReq;
                end
                if (col_q == ColLast) begin
                    col_d = '0;
                    row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (frame_start) begin
            col_d = '0;
            row_d = '0;
        end
    end

    always_ff @(posedge tracer_clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            col_q      <= '0;
            row_q      <= '0;
            col_addr_q <= '0;
            row_addr_q <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            col_addr_q <= col_addr_d;
            row_addr_q <= row_addr_d;
            dout_q     <= dout_d;
        end
    end

`ifdef RAY_SCAN_COLLISION_EN
    logic [3:0] flags_q, flags_d;
    logic [3:0] sig_q, sig_d;

    // Bit order {left, right, front, back}; final pixel's hit lands in flags_q before its write.
    always_comb begin
        flags_d = flags_q;
        sig_d   = sig_q;
        if (frame_start) begin
            flags_d = '0;
        end else if ((state_q == StReq) && bus.ray_ack && bus.ray_hit) begin
            flags_d = flags_q | {col_q == '0, col_q == ColLast, 1'b1, row_q == RowLast};
        end
        if (frame_done) begin
            sig_d = flags_q;
        end
    end

    always_ff @(posedge tracer_clk) begin
        if (!rst) begin
            flags_q <= '0;
            sig_q   <= '0;
        end else begin
            flags_q <= flags_d;
            sig_q   <= sig_d;
        end
    end

    assign collision_sig = sig_q;
`else
    assign collision_sig = 4'b0000;
`endif

    assign busy         = (state_q != StIdle);
    assign bus.ray_req  = ray_req;
    assign bus.ray_col  = col_q;
    assign bus.ray_row  = row_q;
    assign bus.fb_we    = fb_we;
    assign bus.col_addr = col_addr_q;
    assign bus.row_addr = row_addr_q;
    assign bus.dout     = dout_q;

endmodule

// File: tb/tb_ray_scan_host.sv
// Directed scoreboard bench for ray_scan_host on a 4x2 frame; a responder plays the tracer.
module tb_ray_scan_host;

    localparam int COLS  = 4;
    localparam int ROWS  = 2;
    localparam int COL_W = 2;
    localparam int ROW_W = 1;
    localparam int PIX_W = 12;

`ifdef RAY_SCAN_COLLISION_EN
    localparam logic [3:0] ExpHitSig = 4'b1111;
`else
    localparam logic [3:0] ExpHitSig = 4'b0000;
`endif

    logic       tracer_clk = 1'b0;
    logic       rst        = 1'b0;
    logic       start      = 1'b0;
    logic       continuous = 1'b0;
    logic       busy;
    logic       frame_done;
    logic [3:0] collision_sig;

    ray_scan_host_if #(.COL_W(COL_W), .ROW_W(ROW_W), .PIX_W(PIX_W)) bus ();

    ray_scan_host #(
        .COLS (COLS),
        .ROWS (ROWS),
        .COL_W(COL_W),
        .ROW_W(ROW_W),
        .PIX_W(PIX_W)
    ) dut (
        .tracer_clk   (tracer_clk),
        .rst          (rst),
        .start        (start),
        .continuous   (continuous),
        .busy         (busy),
        .frame_done   (frame_done),
        .collision_sig(collision_sig),
        .bus          (bus)
    );

    always #5 tracer_clk = ~tracer_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        logic [PIX_W-1:0] color;
        logic             last;
    } exp_t;

    exp_t sb[$];

    function automatic logic [PIX_W-1:0] pix_color(input int idx, input int c, input int r);
        return PIX_W'((idx % 16) * 256 + c * 16 + r + 1);
    endfunction

    task automatic push_frame(input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.col   = COL_W'(i % COLS);
            e.row   = ROW_W'(i / COLS);
            e.color = pix_color(idx, i % COLS, i / COLS);
            e.last  = (i == COLS * ROWS - 1);
            sb.push_back(e);
        end
    endtask

    // Monitor: pops the scoreboard on every framebuffer write.
    int frames_done   = 0;
    int cyc           = 0;
    int last_we       = -1;
    bit gap_en        = 1'b0;
    bit expect_chain  = 1'b0;
    bit chain_pending = 1'b0;

    always @(posedge tracer_clk) cyc <= cyc + 1;

    always @(negedge tracer_clk) begin
        exp_t e;
        if (chain_pending) begin
            chain_pending = 1'b0;
            chk("chain_req", bus.ray_req, 1);
            chk("chain_col", bus.ray_col, 0);
            chk("chain_row", bus.ray_row, 0);
        end
        if (frame_done && !bus.fb_we) chk("done_without_we", frame_done, 0);
        if (bus.fb_we) begin
            chk("spurious_write", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wr_col", bus.col_addr, e.col);
                chk("wr_row", bus.row_addr, e.row);
                chk("wr_dout", bus.dout, e.color);
                chk("wr_done", frame_done, e.last);
            end
            if (gap_en && last_we >= 0) chk("write_gap", cyc - last_we, 2);
            last_we = cyc;
            if (frame_done) begin
                frames_done++;
                if (expect_chain) chain_pending = 1'b1;
            end
        end
    end

    // Tracer responder: acks in the first REQ cycle except for an optional stall on (2,0).
    bit stall_en     = 1'b0;
    bit stall_done   = 1'b0;
    bit stalling     = 1'b0;
    int stall_cycles = 0;
    int hit_frame    = -1;

    always @(negedge tracer_clk) begin
        if (!rst) begin
            bus.ray_ack   = 1'b0;
            bus.ray_color = '0;
            bus.ray_hit   = 1'b0;
            stalling      = 1'b0;
        end else if (stalling) begin
            chk("stall_req", bus.ray_req, 1);
            chk("stall_col", bus.ray_col, 2);
            chk("stall_row", bus.ray_row, 0);
            stall_cycles++;
            if (stall_cycles == 5) begin
                bus.ray_ack   = 1'b1;
                bus.ray_color = pix_color(frames_done, 2, 0);
                stalling      = 1'b0;
                stall_done    = 1'b1;
            end
        end else if (stall_en && !stall_done && bus.ray_req &&
                     bus.ray_col == 2 && bus.ray_row == 0) begin
            stalling      = 1'b1;
            stall_cycles  = 1;
            bus.ray_ack   = 1'b0;
            bus.ray_color = 12'hBAD;
        end else begin
            bus.ray_ack   = 1'b1;
            bus.ray_color = pix_color(frames_done, int'(bus.ray_col), int'(bus.ray_row));
            bus.ray_hit   = (frames_done == hit_frame) && (bus.ray_row == 1) &&
                            (bus.ray_col == 0 || bus.ray_col == 3);
        end
    end

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge tracer_clk);
            n++;
        end
        chk("frame_timeout", 32'(frames_done >= target), 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge tracer_clk);
        start = 1'b0;
    endtask

    initial begin
        bit found;
        bus.ray_ack   = 1'b0;
        bus.ray_color = '0;
        bus.ray_hit   = 1'b0;

        // Reset state
        repeat (3) @(negedge tracer_clk);
        chk("rst_busy", busy, 0);
        chk("rst_req", bus.ray_req, 0);
        chk("rst_we", bus.fb_we, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_coll", collision_sig, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_col", bus.ray_col, 0);
        rst = 1'b1;
        @(negedge tracer_clk);

        // Single frame, ack tied high: back-to-back writes two cycles apart
        gap_en = 1'b1;
        push_frame(0, 8);
        pulse_start();
        chk("busy_run", busy, 1);
        wait_frames(1, 100);
        repeat (3) @(negedge tracer_clk);
        gap_en = 1'b0;
        chk("f1_idle", busy, 0);
        chk("f1_req", bus.ray_req, 0);
        chk("f1_sb_empty", sb.size(), 0);
        chk("f1_hold_dout", bus.dout, pix_color(0, 3, 1));
        chk("f1_hold_col", bus.col_addr, 3);
        chk("f1_hold_row", bus.row_addr, 1);

        // Delayed ack on (2,0)
        stall_en = 1'b1;
        push_frame(1, 8);
        pulse_start();
        wait_frames(2, 200);
        repeat (2) @(negedge tracer_clk);
        stall_en = 1'b0;
        chk("stall_seen", stall_done, 1);
        chk("stall_len", stall_cycles, 5);
        chk("f2_sb_empty", sb.size(), 0);

        // Continuous frames, hits in the first, a mid-frame start, then stop
        continuous   = 1'b1;
        expect_chain = 1'b1;
        hit_frame    = 2;
        push_frame(2, 8);
        push_frame(3, 8);
        pulse_start();
        wait_frames(3, 200);
        expect_chain = 1'b0;
        @(negedge tracer_clk);
        chk("coll_hits", collision_sig, ExpHitSig);
        chk("busy_chain", busy, 1);
        pulse_start();
        continuous = 1'b0;
        wait_frames(4, 200);
        @(negedge tracer_clk);
        chk("coll_clear", collision_sig, 0);
        repeat (3) @(negedge tracer_clk);
        chk("f4_idle", busy, 0);
        chk("f4_sb_empty", sb.size(), 0);

        // Reset in REQ at (3,0), then a clean restart
        push_frame(4, 3);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (bus.ray_req && bus.ray_col == 3 && bus.ray_row == 0) found = 1'b1;
            else @(negedge tracer_clk);
        end
        chk("reach_3_0", found, 1);
        rst = 1'b0;
        @(negedge tracer_clk);
        rst = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_req", bus.ray_req, 0);
        chk("abort_we", bus.fb_we, 0);
        chk("abort_coll", collision_sig, 0);
        chk("abort_dout", bus.dout, 0);
        chk("abort_col", bus.ray_col, 0);
        chk("abort_sb", sb.size(), 0);
        push_frame(4, 8);
        pulse_start();
        wait_frames(5, 100);
        repeat (2) @(negedge tracer_clk);
        chk("f5_idle", busy, 0);
        chk("f5_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
